// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with flush, NOP bubbles and a drop counter.
// Define PIPE_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             accept;
  logic             stalled;
  logic             skid_held;
  logic [SW-1:0]    drop_sum;

`ifdef PIPE_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  assign in_ready  = ~skid_valid_q;
  assign skid_held = skid_valid_q;
`else
  assign in_ready  = ~out_valid_q | out_ready;
  assign skid_held = 1'b0;
`endif

  assign accept  = in_valid & in_ready;
  assign stalled = out_valid_q & ~out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign drop_cnt  = drop_cnt_q;

  // Saturating count of beats lost to a flush: stalled output, skid, new accept.
  always_comb begin
    drop_sum = {2'b00, drop_cnt_q}
             + SW'(stalled)
             + SW'(skid_held)
             + SW'(accept);
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      if (drop_sum > CNT_MAX) drop_cnt_d = CNT_MAX[CNT_W-1:0];
      else                    drop_cnt_d = drop_sum[CNT_W-1:0];
    end
  end

`ifdef PIPE_SKID_EN
  // Output/skid next state: skid drains first so beats leave in order.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      out_data_d   = NOP_VALUE;
      skid_valid_d = 1'b0;
    end else if (!stalled) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = accept;
        if (accept) skid_data_d = in_data;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = NOP_VALUE;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // Skid entry register.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  // Output next state: load on accept, hold on stall, bubble when drained.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_data_d  = NOP_VALUE;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
    end else if (!stalled) begin
      out_valid_d = 1'b0;
      out_data_d  = NOP_VALUE;
    end
  end
`endif

  // Output register and drop counter.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= NOP_VALUE;
      drop_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg.
// Directed vectors push expected beats; a negedge monitor pops and compares.
module tb_pipe_stage_reg;

  localparam int          W   = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          CW  = 2;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          CLK;
  logic          Reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] drop_cnt;

  pipe_stage_reg #(
    .WIDTH(W),
    .NOP_VALUE(NOP),
    .CNT_W(CW)
  ) dut (
    .CLK(CLK),
    .Reset_n(Reset_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  int          checks = 0;
  int          errors = 0;
  int          xfers  = 0;
  bit          mon_en = 1'b0;
  logic [31:0] q[$];
  logic [31:0] exp_v;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every downstream transfer must match the next queued beat.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        xfers++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got %0h want none", out_data);
        end else begin
          exp_v = q.pop_front();
          chk("out_data", out_data, exp_v);
        end
      end else if (out_valid !== 1'b1) begin
        chk("bubble_nop", out_data, NOP);
      end
    end
  end

  task automatic cyc(input logic iv, input logic [31:0] d,
                     input logic ordy, input logic fl,
                     input logic eir, input bit push);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge CLK);
    chk("in_ready", in_ready, eir);
    if (push) q.push_back(d);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    mon_en = 1'b1;
    @(negedge CLK);
    chk("rst_valid", out_valid, 0);
    chk("rst_drop", drop_cnt, 0);
    @(posedge CLK);
    #1;
    Reset_n = 1'b1;
    cyc(0, 0, 1, 0, 1, 0);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_drop", drop_cnt, 0);

    // Stream
    cyc(1, 32'h1, 1, 0, 1, 1);
    cyc(1, 32'h2, 1, 0, 1, 1);
    cyc(1, 32'h3, 1, 0, 1, 1);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    chk("stream_xfers", xfers, 3);

    // Stall
    cyc(1, 32'hA, 1, 0, 1, 1);
    if (SKID) begin
      cyc(1, 32'hB, 0, 0, 1, 1);
      cyc(1, 32'hC, 0, 0, 0, 0);
      cyc(1, 32'hC, 0, 0, 0, 0);
      cyc(1, 32'hC, 1, 0, 0, 0);
      cyc(1, 32'hC, 1, 0, 1, 1);
    end else begin
      cyc(1, 32'hB, 0, 0, 0, 0);
      cyc(1, 32'hB, 0, 0, 0, 0);
      cyc(1, 32'hB, 0, 0, 0, 0);
      cyc(1, 32'hB, 1, 0, 1, 1);
      cyc(1, 32'hC, 1, 0, 1, 1);
    end
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    chk("stall_xfers", xfers, 6);

    // Flush with held beats
    cyc(1, 32'h55, 1, 0, 1, 0);
    if (SKID) begin
      cyc(1, 32'h66, 0, 0, 1, 0);
      cyc(1, 32'h77, 0, 1, 0, 0);
    end else begin
      cyc(1, 32'h66, 0, 1, 0, 0);
    end
    cyc(0, 0, 0, 0, 1, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_drop", drop_cnt, SKID ? 2 : 1);

    // Flush while the held beat transfers out
    cyc(1, 32'h99, 1, 0, 1, 1);
    cyc(0, 0, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    chk("flush_xfer_drop", drop_cnt, SKID ? 2 : 1);
    chk("flush_xfer_cnt", xfers, 7);

    // Saturation
    Reset_n = 1'b0;
    cyc(0, 0, 1, 0, 1, 0);
    Reset_n = 1'b1;
    chk("rst2_drop", drop_cnt, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 32'h100 + k, 1, 0, 1, 0);
      cyc(0, 0, 0, 1, SKID, 0);
      chk("sat_drop", drop_cnt, (k > 3) ? 3 : k);
    end

    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    chk("queue_empty", q.size(), 0);
    chk("total_xfers", xfers, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
